// File: rtl/cu_seq_mem.sv
// Multi-cycle sequencer for the accumulator CPU: it owns PC/IR/EA, fetches over a
// req/ack port, resolves indirection and strobes the datapath. Outputs are Moore.
//
// state      | meaning
// IDLE       | stopped, PC preset allowed
// FETCH      | read instruction at PC
// DECODE     | classify opcode, latch EA
// INDIRECT   | read pointer at EA
// MEM_EXEC   | memory-reference access (branch: PC<=EA)
// WAIT_EX    | wait for datapath i_ex_done
// ISZ_WB     | write back incremented operand, apply skip
// REG_EXEC   | register-reference strobe until done
// DONE       | one-cycle completion pulse
// HALT       | halted (HLT or illegal), leave when run drops
module cu_seq_mem #(
  parameter int DWIDTH = 16,
  parameter int RESET_PC = 0,
  localparam int AWIDTH = DWIDTH - 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_run,
  input  logic              i_pc_load,
  input  logic [AWIDTH-1:0] i_pc_value,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [AWIDTH-1:0] o_mem_addr,
  input  logic              i_mem_ack,
  input  logic [DWIDTH-1:0] i_mem_rdata,
  output logic              o_op_add,
  output logic              o_op_load,
  output logic              o_op_store,
  output logic              o_op_isz,
  output logic [6:0]        o_rr,
  output logic [7:0]        o_imm,
  input  logic              i_ex_done,
  input  logic              i_skip,
  output logic [AWIDTH-1:0] o_pc,
  output logic [DWIDTH-1:0] o_ir,
  output logic [3:0]        o_state,
  output logic              o_instr_done,
  output logic              o_halted,
  output logic              o_illegal
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_INDIRECT = 4'd3,
    S_MEM_EXEC = 4'd4,
    S_WAIT_EX  = 4'd5,
    S_ISZ_WB   = 4'd6,
    S_REG_EXEC = 4'd7,
    S_DONE     = 4'd8,
    S_HALT     = 4'd9
  } state_t;

  state_t            state_q, state_nx;
  logic [AWIDTH-1:0] pc_q, pc_nx, ea_q, ea_nx;
  logic [DWIDTH-1:0] ir_q, ir_nx;
  logic              skip_q, skip_nx, illegal_q, illegal_nx, gap_q, gap_nx;
  logic              i_bit;
  logic [2:0]        opcode;
  logic              is_add, is_load, is_store, is_branch, is_isz, in_mx;
  logic [6:0]        rr_bits, rr_sel;
  logic              rr_onehot, rr_valid, rr_hlt;
  logic              mem_req, ack_ok;

  assign i_bit     = ir_q[DWIDTH-1];
  assign opcode    = ir_q[DWIDTH-2 -: 3];
  assign is_add    = (opcode == 3'd1);
  assign is_load   = (opcode == 3'd2);
  assign is_store  = (opcode == 3'd3);
  assign is_branch = (opcode == 3'd4);
  assign is_isz    = (opcode == 3'd6);

  // Candidate reg-ref bits in order CLA,CLE,CMA,CIR,CIL,INC,HLT; bits 4:1 must stay clear.
  assign rr_bits   = {ir_q[11], ir_q[10], ir_q[9], ir_q[7], ir_q[6], ir_q[5], ir_q[0]};
  assign rr_onehot = (rr_bits != 7'd0) && ((rr_bits & (rr_bits - 7'd1)) == 7'd0)
                     && (ir_q[4:1] == 4'd0);
  assign rr_valid  = ir_q[8] || rr_onehot;
  assign rr_hlt    = !ir_q[8] && rr_onehot && ir_q[0];
  assign rr_sel    = ir_q[8] ? 7'b0001000 : {rr_bits[6:4], 1'b0, rr_bits[3:1]};

  // gap_q holds req low for one cycle after every accepted access.
  always_comb begin
    mem_req = 1'b0;
    case (state_q)
      S_FETCH, S_INDIRECT, S_ISZ_WB: mem_req = !gap_q;
      S_MEM_EXEC:                    mem_req = !gap_q && !is_branch;
      default:                       mem_req = 1'b0;
    endcase
  end

  assign ack_ok = mem_req && i_mem_ack;

  always_comb begin
    state_nx   = state_q;
    pc_nx      = pc_q;
    ir_nx      = ir_q;
    ea_nx      = ea_q;
    skip_nx    = skip_q;
    illegal_nx = illegal_q;
    gap_nx     = ack_ok;
    case (state_q)
      S_IDLE: begin
        if (i_pc_load) pc_nx = i_pc_value;
        if (i_run) state_nx = S_FETCH;
      end
      S_FETCH: if (ack_ok) begin
        ir_nx    = i_mem_rdata;
        pc_nx    = pc_q + AWIDTH'(1);
        state_nx = S_DECODE;
      end
      S_DECODE: begin
        ea_nx = ir_q[AWIDTH-1:0];
        if (opcode == 3'd7 && !i_bit) state_nx = S_REG_EXEC;
        else if (opcode == 3'd7 || opcode == 3'd0 || opcode == 3'd5) begin
          illegal_nx = 1'b1;
          state_nx   = S_HALT;
        end else if (i_bit) state_nx = S_INDIRECT;
        else state_nx = S_MEM_EXEC;
      end
      S_INDIRECT: if (ack_ok) begin
        ea_nx    = i_mem_rdata[AWIDTH-1:0];
        state_nx = S_MEM_EXEC;
      end
      S_MEM_EXEC: begin
        if (is_branch) begin
          pc_nx    = ea_q;
          state_nx = S_DONE;
        end else if (ack_ok) state_nx = is_store ? S_DONE : S_WAIT_EX;
      end
      S_WAIT_EX: if (i_ex_done) begin
        if (is_isz) begin
          skip_nx  = i_skip;
          state_nx = S_ISZ_WB;
        end else state_nx = S_DONE;
      end
      S_ISZ_WB: if (ack_ok) begin
        if (skip_q) pc_nx = pc_q + AWIDTH'(1);
        state_nx = S_DONE;
      end
      S_REG_EXEC: begin
        if (!rr_valid) begin
          illegal_nx = 1'b1;
          state_nx   = S_HALT;
        end else if (rr_hlt) state_nx = S_HALT;
        else if (i_ex_done) state_nx = S_DONE;
      end
      S_DONE: state_nx = i_run ? S_FETCH : S_IDLE;
      S_HALT: if (!i_run) begin
        illegal_nx = 1'b0;
        state_nx   = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_nx;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q      <= AWIDTH'(RESET_PC);
      ir_q      <= '0;
      ea_q      <= '0;
      skip_q    <= 1'b0;
      illegal_q <= 1'b0;
      gap_q     <= 1'b0;
    end else begin
      pc_q      <= pc_nx;
      ir_q      <= ir_nx;
      ea_q      <= ea_nx;
      skip_q    <= skip_nx;
      illegal_q <= illegal_nx;
      gap_q     <= gap_nx;
    end
  end

  assign in_mx        = (state_q == S_MEM_EXEC) || (state_q == S_WAIT_EX);
  assign o_mem_req    = mem_req;
  assign o_mem_we     = ((state_q == S_MEM_EXEC) && is_store) || (state_q == S_ISZ_WB);
  assign o_mem_addr   = (state_q == S_FETCH) ? pc_q :
                        ((state_q == S_INDIRECT) || (state_q == S_MEM_EXEC) ||
                         (state_q == S_ISZ_WB)) ? ea_q : '0;
  assign o_op_add     = in_mx && is_add;
  assign o_op_load    = in_mx && is_load;
  assign o_op_store   = in_mx && is_store;
  assign o_op_isz     = in_mx && is_isz;
  assign o_rr         = ((state_q == S_REG_EXEC) && rr_valid && !rr_hlt) ? rr_sel : 7'd0;
  assign o_imm        = ir_q[7:0];
  assign o_pc         = pc_q;
  assign o_ir         = ir_q;
  assign o_state      = state_q;
  assign o_instr_done = (state_q == S_DONE);
  assign o_halted     = (state_q == S_HALT);
  assign o_illegal    = illegal_q;

endmodule

// File: tb/tb_cu_seq_mem.sv
// Bench for cu_seq_mem: vector table of single instructions with a memory-access
// scoreboard, plus hand sequences for reset, back-to-back run and reset mid-fetch.
module tb_cu_seq_mem;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_run = 1'b0, i_pc_load = 1'b0;
  logic [11:0] i_pc_value = '0;
  logic        o_mem_req, o_mem_we;
  logic [11:0] o_mem_addr;
  logic        i_mem_ack = 1'b0;
  logic [15:0] i_mem_rdata = '0;
  logic        o_op_add, o_op_load, o_op_store, o_op_isz;
  logic [6:0]  o_rr;
  logic [7:0]  o_imm;
  logic        i_ex_done = 1'b0, i_skip = 1'b0;
  logic [11:0] o_pc;
  logic [15:0] o_ir;
  logic [3:0]  o_state;
  logic        o_instr_done, o_halted, o_illegal;

  cu_seq_mem #(.DWIDTH(16), .RESET_PC(0)) dut (
    .clk(clk), .reset_n(reset_n), .i_run(i_run), .i_pc_load(i_pc_load),
    .i_pc_value(i_pc_value), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
    .o_mem_addr(o_mem_addr), .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
    .o_op_add(o_op_add), .o_op_load(o_op_load), .o_op_store(o_op_store),
    .o_op_isz(o_op_isz), .o_rr(o_rr), .o_imm(o_imm), .i_ex_done(i_ex_done),
    .i_skip(i_skip), .o_pc(o_pc), .o_ir(o_ir), .o_state(o_state),
    .o_instr_done(o_instr_done), .o_halted(o_halted), .o_illegal(o_illegal));

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic        we;
    logic [11:0] addr;
  } acc_t;
  acc_t expq[$];
  acc_t exp_acc;

  logic [15:0] mem [0:4095];
  int mem_waits = 0, wcnt = 0;
  int ex_delay = 0, ecnt = 0;
  logic skip_val = 1'b0;

  // Memory responder: acks after mem_waits stall cycles, checks each access against the queue.
  always @(negedge clk) begin
    if (o_mem_req) begin
      if (wcnt >= mem_waits) begin
        i_mem_ack   = 1'b1;
        i_mem_rdata = mem[o_mem_addr];
        if (expq.size() == 0) begin
          check("unexpected_acc", {19'd0, o_mem_we, o_mem_addr}, 32'hFFFF_FFFF);
        end else begin
          exp_acc = expq.pop_front();
          check("mem_acc", {19'd0, o_mem_we, o_mem_addr}, {19'd0, exp_acc.we, exp_acc.addr});
        end
      end else begin
        i_mem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      i_mem_ack = 1'b0;
      wcnt = 0;
    end
  end

  // Datapath responder: raises i_ex_done ex_delay cycles after a strobe appears.
  always @(negedge clk) begin
    if (o_op_add || o_op_load || o_op_isz || (o_rr != 7'd0)) begin
      if (ecnt >= ex_delay) i_ex_done = 1'b1;
      else begin
        i_ex_done = 1'b0;
        ecnt++;
      end
    end else begin
      i_ex_done = 1'b0;
      ecnt = 0;
    end
    i_skip = skip_val;
  end

  typedef struct {
    logic [11:0] pc0;
    logic [15:0] instr;
    logic [15:0] ind;
    logic        skip;
    int          waits;
    int          exd;
    logic        halt;
    logic        ill;
    logic [11:0] exp_pc;
    int          exp_cyc;   // 0 = not checked
    logic [10:0] exp_strb;  // {add,load,store,isz,rr[6:0]}
  } vec_t;

  localparam int NV = 21;
  vec_t vt [NV];

  // Expected access list from the instruction semantics.
  task automatic push_exp(input vec_t v);
    logic [2:0]  op;
    logic [11:0] ea;
    op = v.instr[14:12];
    expq.push_back({1'b0, v.pc0});
    if (op == 3'd1 || op == 3'd2 || op == 3'd3 || op == 3'd4 || op == 3'd6) begin
      ea = v.instr[11:0];
      if (v.instr[15]) begin
        expq.push_back({1'b0, ea});
        ea = v.ind[11:0];
      end
      if (op != 3'd4) expq.push_back({(op == 3'd3), ea});
      if (op == 3'd6) expq.push_back({1'b1, ea});
    end
  endtask

  task automatic run_vec(input vec_t v);
    int          cyc;
    logic [10:0] strb;
    logic [11:0] dec_pc, pc_inc;
    logic        seen_dec, ended;
    mem[v.pc0] = v.instr;
    if (v.instr[15]) mem[v.instr[11:0]] = v.ind;
    mem_waits = v.waits;
    ex_delay  = v.exd;
    skip_val  = v.skip;
    push_exp(v);
    @(negedge clk);
    i_pc_load = 1'b1; i_pc_value = v.pc0; i_run = 1'b1;
    @(negedge clk);
    i_pc_load = 1'b0; i_run = 1'b0;
    cyc = 0; strb = '0; seen_dec = 1'b0; ended = 1'b0; dec_pc = '0;
    for (int k = 0; k < 60 && !ended; k++) begin
      if (k > 0) @(negedge clk);
      cyc++;
      strb |= {o_op_add, o_op_load, o_op_store, o_op_isz, o_rr};
      if (o_state == 4'd2 && !seen_dec) begin
        dec_pc = o_pc;
        seen_dec = 1'b1;
      end
      if (o_instr_done || o_halted) ended = 1'b1;
    end
    pc_inc = v.pc0 + 12'd1;
    check("finished", {31'd0, ended}, 32'd1);
    check("halted", {31'd0, o_halted}, {31'd0, v.halt});
    check("illegal", {31'd0, o_illegal}, {31'd0, v.ill});
    check("pc_end", {20'd0, o_pc}, {20'd0, v.exp_pc});
    check("pc_fetch_inc", {20'd0, dec_pc}, {20'd0, pc_inc});
    check("strobes", {21'd0, strb}, {21'd0, v.exp_strb});
    if (v.exp_cyc > 0) check("cycles", cyc, v.exp_cyc);
    if (v.instr[15:12] == 4'h7 && v.instr[8]) check("imm", {24'd0, o_imm}, {24'd0, v.instr[7:0]});
    @(negedge clk);
    check("back_idle", {28'd0, o_state}, 32'd0);
    check("illegal_clr", {31'd0, o_illegal}, 32'd0);
    check("acc_drained", expq.size(), 0);
    expq.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 4096; a++) mem[a] = 16'h0000;
    //          pc0      instr     ind       sk    w  exd hlt   ill   exp_pc   cyc strobes
    vt[0]  = '{12'h000, 16'h2010, 16'h0000, 1'b0, 0, 0, 1'b0, 1'b0, 12'h001, 5, 11'h200};
    vt[1]  = '{12'h000, 16'hA020, 16'h0345, 1'b0, 0, 0, 1'b0, 1'b0, 12'h001, 0, 11'h200};
    vt[2]  = '{12'h003, 16'h1050, 16'h0000, 1'b0, 0, 0, 1'b0, 1'b0, 12'h004, 5, 11'h400};
    vt[3]  = '{12'h004, 16'h3060, 16'h0000, 1'b0, 0, 0, 1'b0, 1'b0, 12'h005, 4, 11'h100};
    vt[4]  = '{12'h002, 16'h4123, 16'h0000, 1'b0, 0, 0, 1'b0, 1'b0, 12'h123, 4, 11'h000};
    vt[5]  = '{12'h005, 16'h6030, 16'h0000, 1'b1, 0, 0, 1'b0, 1'b0, 12'h007, 6, 11'h080};
    vt[6]  = '{12'h005, 16'h6030, 16'h0000, 1'b0, 0, 0, 1'b0, 1'b0, 12'h006, 6, 11'h080};
    vt[7]  = '{12'h000, 16'h7800, 16'h0000, 1'b0, 0, 0, 1'b0, 1'b0, 12'h001, 4, 11'h040};
    vt[8]  = '{12'h000, 16'h7800, 16'h0000, 1'b0, 0, 2, 1'b0, 1'b0, 12'h001, 6, 11'h040};
    vt[9]  = '{12'h010, 16'h71AB, 16'h0000, 1'b0, 0, 0, 1'b0, 1'b0, 12'h011, 4, 11'h008};
    vt[10] = '{12'h020, 16'h7020, 16'h0000, 1'b0, 0, 0, 1'b0, 1'b0, 12'h021, 4, 11'h001};
    vt[11] = '{12'h030, 16'h7080, 16'h0000, 1'b0, 0, 0, 1'b0, 1'b0, 12'h031, 4, 11'h004};
    vt[12] = '{12'hFFF, 16'h4123, 16'h0000, 1'b0, 3, 0, 1'b0, 1'b0, 12'h123, 7, 11'h000};
    vt[13] = '{12'h040, 16'h7005, 16'h0000, 1'b0, 0, 0, 1'b1, 1'b1, 12'h041, 0, 11'h000};
    vt[14] = '{12'h050, 16'h7001, 16'h0000, 1'b0, 0, 0, 1'b1, 1'b0, 12'h051, 0, 11'h000};
    vt[15] = '{12'h060, 16'h5010, 16'h0000, 1'b0, 0, 0, 1'b1, 1'b1, 12'h061, 0, 11'h000};
    vt[16] = '{12'h070, 16'hF010, 16'h0000, 1'b0, 0, 0, 1'b1, 1'b1, 12'h071, 0, 11'h000};
    vt[17] = '{12'h080, 16'h7C00, 16'h0000, 1'b0, 0, 0, 1'b1, 1'b1, 12'h081, 0, 11'h000};
    vt[18] = '{12'h090, 16'h0010, 16'h0000, 1'b0, 0, 0, 1'b1, 1'b1, 12'h091, 0, 11'h000};
    vt[19] = '{12'h0A0, 16'h2055, 16'h0000, 1'b0, 2, 0, 1'b0, 1'b0, 12'h0A1, 9, 11'h200};
    vt[20] = '{12'h0B0, 16'hB077, 16'h0ABC, 1'b0, 0, 0, 1'b0, 1'b0, 12'h0B1, 0, 11'h100};

    #2;
    check("rst_state", {28'd0, o_state}, 32'd0);
    check("rst_pc", {20'd0, o_pc}, 32'd0);
    check("rst_req", {31'd0, o_mem_req}, 32'd0);
    check("rst_ir", {16'd0, o_ir}, 32'd0);
    check("rst_flags", {28'd0, o_instr_done, o_halted, o_illegal, (o_rr != 7'd0)}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++) run_vec(vt[i]);

    // Two reg-ref instructions with run held: DONE must go straight back to FETCH.
    mem[12'h100] = 16'h7020;
    mem[12'h101] = 16'h7040;
    mem_waits = 0; ex_delay = 0;
    expq.push_back({1'b0, 12'h100});
    expq.push_back({1'b0, 12'h101});
    @(negedge clk);
    i_pc_load = 1'b1; i_pc_value = 12'h100; i_run = 1'b1;
    @(negedge clk);
    i_pc_load = 1'b0;
    for (int k = 0; k < 20 && !o_instr_done; k++) @(negedge clk);
    check("b2b_done1", {31'd0, o_instr_done}, 32'd1);
    @(negedge clk);
    check("b2b_refetch", {28'd0, o_state}, 32'd1);
    i_run = 1'b0;
    for (int k = 0; k < 20 && !o_instr_done; k++) @(negedge clk);
    check("b2b_done2", {31'd0, o_instr_done}, 32'd1);
    check("b2b_pc", {20'd0, o_pc}, 32'h102);
    @(negedge clk);
    check("b2b_idle", {28'd0, o_state}, 32'd0);
    check("b2b_drained", expq.size(), 0);
    expq.delete();

    // Reset while a fetch request is stalled.
    mem_waits = 10;
    expq.push_back({1'b0, 12'h200});
    @(negedge clk);
    i_pc_load = 1'b1; i_pc_value = 12'h200; i_run = 1'b1;
    @(negedge clk);
    i_pc_load = 1'b0; i_run = 1'b0;
    @(negedge clk);
    check("midreq_req", {31'd0, o_mem_req}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("midreq_req_drop", {31'd0, o_mem_req}, 32'd0);
    check("midreq_state", {28'd0, o_state}, 32'd0);
    check("midreq_pc", {20'd0, o_pc}, 32'd0);
    check("midreq_ir", {16'd0, o_ir}, 32'd0);
    expq.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
